// File: rtl/device_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the default widths/depth and the fetch FSM state encoding so the
// sequencer, its sub-module and any checker agree on one encoding.
package device_pkg;

  localparam int PC_BITS_DEF        = 8;   // width of every program-counter value
  localparam int INST_MEM_DEPTH_DEF = 24;  // valid instruction addresses 0..DEPTH-1
  localparam int INST_BITS_DEF      = 16;  // instruction word width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // parked, no request outstanding
    ST_REQ   = 3'd1,  // single-cycle read strobe
    ST_WAIT  = 3'd2,  // waiting for read data
    ST_HOLD  = 3'd3,  // instruction buffered, offered to consumer
    ST_FAULT = 3'd4   // bad branch target seen; left only by reset
  } fetch_state_t;

endpackage

// File: rtl/device_pc_incr.sv
// Sequential program-counter increment with wrap-around.
// Ports:
//   i_pc     : current fetch address (PC_BITS)
//   o_pc_inc : i_pc + 1, or 0 when i_pc is the last valid address
module device_pc_incr
  import device_pkg::*;
#(
  parameter int PC_BITS        = PC_BITS_DEF,
  parameter int INST_MEM_DEPTH = INST_MEM_DEPTH_DEF
) (
  input  logic [PC_BITS-1:0] i_pc,
  output logic [PC_BITS-1:0] o_pc_inc
);

  // ">=" rather than "==" so an out-of-range value can never walk further
  // out; it folds back to address 0.
  assign o_pc_inc = (i_pc >= PC_BITS'(INST_MEM_DEPTH - 1)) ? '0 : i_pc + PC_BITS'(1);

endmodule

// File: rtl/device_fetch_seq.sv
// Instruction fetch sequencer: issues one instruction-memory read at a time,
// buffers the returned word and offers it to a consumer, with branch
// redirects and a sticky fault for out-of-range branch targets.
//
// Ports:
//   i_clk, i_nrst           : clock, asynchronous active-low reset
//   i_run                   : level, fetching enabled while high
//   i_br_valid/i_br_target  : single-cycle branch redirect
//   o_imem_req/o_imem_addr  : one-cycle read strobe and address
//   i_imem_valid/i_imem_data: read response, 1..N cycles after the strobe
//   o_pc_next               : registered fetch PC (PC register data input)
//   o_inst/o_inst_pc        : buffered instruction and its address
//   o_inst_valid            : buffer holds an instruction
//   i_inst_ready            : consumer accepts
//   o_fault                 : sticky, branch target out of range
//   o_dbg_state             : current FSM state
//
// Consumer handshake: o_inst_valid/o_inst/o_inst_pc are offered and held
// stable until a transfer, which is a cycle where o_inst_valid && i_inst_ready
// at the rising edge. Valid never depends combinationally on ready. The only
// other way the offer is withdrawn is a branch (instruction dropped) or a
// fault.
module device_fetch_seq
  import device_pkg::*;
#(
  parameter int PC_BITS        = PC_BITS_DEF,
  parameter int INST_MEM_DEPTH = INST_MEM_DEPTH_DEF,
  parameter int INST_BITS      = INST_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_run,
  input  logic                 i_br_valid,
  input  logic [PC_BITS-1:0]   i_br_target,
  output logic                 o_imem_req,
  output logic [PC_BITS-1:0]   o_imem_addr,
  input  logic                 i_imem_valid,
  input  logic [INST_BITS-1:0] i_imem_data,
  output logic [PC_BITS-1:0]   o_pc_next,
  output logic [INST_BITS-1:0] o_inst,
  output logic [PC_BITS-1:0]   o_inst_pc,
  output logic                 o_inst_valid,
  input  logic                 i_inst_ready,
  output logic                 o_fault,
  output fetch_state_t         o_dbg_state
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [PC_BITS-1:0]    r_fetch_pc;
  logic [PC_BITS-1:0]    w_pc_inc;
  logic [INST_BITS-1:0]  r_inst;
  logic [PC_BITS-1:0]    r_inst_pc;
  logic                  r_inst_valid;
  logic                  r_fault;
  // Set when a branch lands while a read is outstanding: the response still
  // has to be waited for (one request in flight at a time) but is thrown away.
  logic                  r_discard;

  logic                  w_tgt_in_range;
  logic                  w_br_take;
  logic                  w_br_fault;
  logic                  w_xfer;
  logic                  w_capture;

  device_pc_incr #(
    .PC_BITS        (PC_BITS),
    .INST_MEM_DEPTH (INST_MEM_DEPTH)
  ) u_pc_incr (
    .i_pc     (r_fetch_pc),
    .o_pc_inc (w_pc_inc)
  );

  assign w_tgt_in_range = (32'(i_br_target) < 32'(INST_MEM_DEPTH));
  assign w_br_take      = i_br_valid && w_tgt_in_range && (r_state != ST_FAULT);
  assign w_br_fault     = i_br_valid && !w_tgt_in_range && (r_state != ST_FAULT);
  assign w_xfer         = r_inst_valid && i_inst_ready;
  // Response is kept only if nothing redirected the fetch stream.
  assign w_capture      = (r_state == ST_WAIT) && i_imem_valid && !r_discard &&
                          !i_br_valid;

  // State register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_br_fault) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_run) w_state_nxt = ST_REQ;
        ST_REQ:   w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (i_imem_valid) w_state_nxt = (r_discard || w_br_take) ? ST_REQ : ST_HOLD;
        end
        ST_HOLD: begin
          if (w_br_take)   w_state_nxt = ST_REQ;
          else if (w_xfer) w_state_nxt = i_run ? ST_REQ : ST_IDLE;
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_imem_req  = 1'b0;
    o_imem_addr = '0;
    if (r_state == ST_REQ) begin
      o_imem_req  = 1'b1;
      o_imem_addr = r_fetch_pc;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_fetch_pc   <= '0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_discard    <= 1'b0;
    end else begin
      // Branch wins over the sequential advance of a same-cycle transfer.
      if (w_br_take)
        r_fetch_pc <= i_br_target;
      else if ((r_state == ST_HOLD) && w_xfer)
        r_fetch_pc <= w_pc_inc;

      if ((r_state == ST_WAIT) && i_imem_valid)
        r_discard <= 1'b0;
      else if (w_br_take && ((r_state == ST_REQ) || (r_state == ST_WAIT)))
        r_discard <= 1'b1;

      if (w_capture) begin
        r_inst       <= i_imem_data;
        r_inst_pc    <= r_fetch_pc;
        r_inst_valid <= 1'b1;
      end else if (w_br_fault || ((r_state == ST_HOLD) && (w_xfer || w_br_take))) begin
        r_inst_valid <= 1'b0;
      end

      if (w_br_fault) r_fault <= 1'b1;
    end
  end

  assign o_pc_next    = r_fetch_pc;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_fault      = r_fault;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_device_fetch_seq.sv
// Bench for device_fetch_seq: random stimulus against a transaction-level
// model of the fetch stream, plus directed boundary scenarios.
module tb_device_fetch_seq;
  import device_pkg::*;

  localparam int DEPTH = 24;

  // ---------------- clock / reset / DUT ----------------
  logic         i_clk = 1'b0;
  logic         i_nrst;
  logic         i_run;
  logic         i_br_valid;
  logic [7:0]   i_br_target;
  logic         o_imem_req;
  logic [7:0]   o_imem_addr;
  logic         i_imem_valid;
  logic [15:0]  i_imem_data;
  logic [7:0]   o_pc_next;
  logic [15:0]  o_inst;
  logic [7:0]   o_inst_pc;
  logic         o_inst_valid;
  logic         i_inst_ready;
  logic         o_fault;
  fetch_state_t o_dbg_state;

  always #5 i_clk = ~i_clk;

  device_fetch_seq dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_run        (i_run),
    .i_br_valid   (i_br_valid),
    .i_br_target  (i_br_target),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_valid (i_imem_valid),
    .i_imem_data  (i_imem_data),
    .o_pc_next    (o_pc_next),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .o_inst_valid (o_inst_valid),
    .i_inst_ready (i_inst_ready),
    .o_fault      (o_fault),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_pc;          // address the fetch stream should be at
  logic       prev_hold;       // offer held without transfer last cycle
  logic [15:0] prev_inst;
  logic [7:0] prev_pc;
  int         req_cnt, xfer_cnt;
  logic [7:0] last_req_addr, last_xfer_pc;

  // knobs
  int   model_on, sb_on, ready_mode, ready_pct, br_pct, lat_min, lat_max;
  int   run_rand, run_val, br_on_resp, bad_br;
  logic nrst_val;

  // memory model: one outstanding read
  logic       pend;
  int         pend_cnt;
  logic [7:0] pend_addr;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req",   32'(o_imem_req),   0);
    chk("rst_addr",  32'(o_imem_addr),  0);
    chk("rst_pcnx",  32'(o_pc_next),    0);
    chk("rst_inst",  32'(o_inst),       0);
    chk("rst_ipc",   32'(o_inst_pc),    0);
    chk("rst_ivld",  32'(o_inst_valid), 0);
    chk("rst_fault", 32'(o_fault),      0);
    chk("rst_state", 32'(o_dbg_state),  32'(ST_IDLE));
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Samples outputs at the falling edge, checks them, then drives inputs for
  // the next rising edge and advances the reference model.
  task automatic step();
    logic [7:0] q;
    @(negedge i_clk);
    if (o_imem_req) begin
      req_cnt++;
      last_req_addr = o_imem_addr;
    end
    if (model_on != 0) begin
      chk("pc_next", 32'(o_pc_next), 32'(exp_pc));
      chk("fault_clear", 32'(o_fault), 0);
      if (o_imem_req) begin
        chk("req_addr", 32'(o_imem_addr), 32'(exp_pc));
        chk("req_in_hold", 32'(o_inst_valid), 0);
      end
      if (prev_hold) begin
        chk("hold_valid", 32'(o_inst_valid), 1);
        chk("hold_inst", 32'(o_inst), 32'(prev_inst));
        chk("hold_pc", 32'(o_inst_pc), 32'(prev_pc));
      end
    end
    if ((sb_on != 0) && o_imem_req) begin
      q = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
      chk("sb_req_addr", 32'(o_imem_addr), 32'(q));
    end

    i_nrst = nrst_val;
    i_run  = (run_rand != 0) ? ($urandom_range(0, 9) != 0) : (run_val != 0);
    case (ready_mode)
      0:       i_inst_ready = ($urandom_range(0, 99) < ready_pct);
      1:       i_inst_ready = 1'b0;
      default: i_inst_ready = 1'b1;
    endcase

    i_imem_valid = 1'b0;
    i_imem_data  = 16'($urandom);
    if (pend) begin
      if (pend_cnt <= 1) begin
        i_imem_valid = 1'b1;
        i_imem_data  = mem_word(pend_addr);
        pend         = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (o_imem_req) begin
      pend      = 1'b1;
      pend_cnt  = $urandom_range(lat_min, lat_max);
      pend_addr = o_imem_addr;
    end

    i_br_valid  = 1'b0;
    i_br_target = 8'($urandom);
    if (bad_br != 0) begin
      i_br_valid  = 1'b1;
      i_br_target = 8'($urandom_range(DEPTH, 255));
      bad_br      = 0;
    end else if ((br_on_resp != 0) && i_imem_valid) begin
      i_br_valid  = 1'b1;
      i_br_target = 8'd5;
      br_on_resp  = 0;
    end else if ($urandom_range(0, 99) < br_pct) begin
      i_br_valid  = 1'b1;
      i_br_target = 8'($urandom_range(0, DEPTH - 1));
    end

    if (model_on != 0) begin
      if (o_inst_valid && i_inst_ready) begin
        chk("xfer_pc", 32'(o_inst_pc), 32'(exp_pc));
        chk("xfer_inst", 32'(o_inst), 32'(mem_word(exp_pc)));
        last_xfer_pc = o_inst_pc;
        exp_pc = 8'((int'(exp_pc) + 1) % DEPTH);
        xfer_cnt++;
      end
      if (i_br_valid) exp_pc = i_br_target;
      prev_hold = o_inst_valid && !i_inst_ready && !i_br_valid;
      prev_inst = o_inst;
      prev_pc   = o_inst_pc;
    end
  endtask

  task automatic do_reset();
    model_on = 0;
    nrst_val = 1'b0;
    step();
    #1 chk_reset_vals();
    step();
    nrst_val = 1'b1;
    run_val  = 0;
    step();
    pend      = 1'b0;
    exp_pc    = 8'd0;
    prev_hold = 1'b0;
    model_on  = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0, x0;
    logic [15:0] saved_inst;
    logic [7:0]  saved_pc;

    i_nrst = 1'b1; i_run = 1'b0; i_br_valid = 1'b0; i_br_target = '0;
    i_imem_valid = 1'b0; i_imem_data = '0; i_inst_ready = 1'b0;
    model_on = 0; sb_on = 0; ready_mode = 1; ready_pct = 70; br_pct = 0;
    lat_min = 1; lat_max = 1; run_rand = 0; run_val = 0; br_on_resp = 0; bad_br = 0;
    nrst_val = 1'b1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
    exp_pc = '0; prev_hold = 1'b0; prev_inst = '0; prev_pc = '0;
    req_cnt = 0; xfer_cnt = 0; last_req_addr = '0; last_xfer_pc = '0;

    #2 i_nrst = 1'b0;
    #1 chk_reset_vals();
    do_reset();

    // Sequential fetch through the wrap point, 1-cycle memory, always ready.
    req_cnt = 0;
    for (int i = 0; i < 30; i++) exp_q.push_back(8'(i % DEPTH));
    sb_on = 1; ready_mode = 2; lat_min = 1; lat_max = 1; run_val = 1;
    for (int n = 0; n < 300 && req_cnt < 30; n++) step();
    chk("seq_done", 32'(req_cnt >= 30), 1);
    chk("seq_sb_left", 32'(exp_q.size()), 0);
    sb_on = 0;

    // Branch to 5 in WAIT together with the response.
    br_on_resp = 1;
    for (int n = 0; n < 50 && br_on_resp != 0; n++) step();
    chk("br_wait_fired", 32'(br_on_resp), 0);
    r0 = req_cnt;
    for (int n = 0; n < 50 && req_cnt == r0; n++) step();
    chk("br_wait_addr", 32'(last_req_addr), 5);

    // Consumer stalls 10 cycles in HOLD, then takes exactly one.
    ready_mode = 1;
    for (int n = 0; n < 50 && !o_inst_valid; n++) step();
    chk("stall_valid", 32'(o_inst_valid), 1);
    saved_inst = o_inst;
    saved_pc   = o_inst_pc;
    x0 = xfer_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_inst", 32'(o_inst), 32'(saved_inst));
      chk("stall_pc", 32'(o_inst_pc), 32'(saved_pc));
      chk("stall_noreq", 32'(o_imem_req), 0);
    end
    ready_mode = 2;
    step();
    ready_mode = 1;
    step();
    chk("stall_one_xfer", 32'(xfer_cnt - x0), 1);
    chk("stall_cleared", 32'(o_inst_valid), 0);

    // Random traffic: latency, ready, run and in-range branches all random.
    x0 = xfer_cnt;
    ready_mode = 0; ready_pct = 70; lat_min = 1; lat_max = 3; br_pct = 3; run_rand = 1;
    for (int i = 0; i < 3000; i++) step();
    run_rand = 0; run_val = 1;
    chk("rand_progress", 32'((xfer_cnt - x0) > 100), 1);

    // Out-of-range branch while an instruction is buffered.
    br_pct = 0; ready_mode = 1;
    for (int n = 0; n < 60 && !o_inst_valid; n++) step();
    chk("fault_pre_valid", 32'(o_inst_valid), 1);
    model_on = 0;
    bad_br = 1;
    step();
    step();
    chk("fault_set", 32'(o_fault), 1);
    chk("fault_ivld", 32'(o_inst_valid), 0);
    chk("fault_state", 32'(o_dbg_state), 32'(ST_FAULT));
    br_pct = 5; ready_mode = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("fault_noreq", 32'(o_imem_req), 0);
      chk("fault_sticky", 32'(o_fault), 1);
    end
    br_pct = 0;
    do_reset();

    // Reset in WAIT; the late response must not be buffered.
    ready_mode = 2; lat_min = 3; lat_max = 3; run_val = 1;
    r0 = req_cnt;
    for (int n = 0; n < 20 && req_cnt == r0; n++) step();
    chk("late_req_seen", 32'(req_cnt - r0), 1);
    model_on = 0; run_val = 0; nrst_val = 1'b0;
    step();
    #1 chk_reset_vals();
    nrst_val = 1'b1;
    step();
    step();
    chk("late_delivered", 32'(pend), 0);
    step();
    chk("late_ignored_vld", 32'(o_inst_valid), 0);
    chk("late_ignored_st", 32'(o_dbg_state), 32'(ST_IDLE));
    exp_pc = 8'd0; prev_hold = 1'b0; model_on = 1; lat_min = 1; lat_max = 1; run_val = 1;
    r0 = req_cnt;
    for (int n = 0; n < 20 && req_cnt == r0; n++) step();
    chk("restart_addr", 32'(last_req_addr), 0);
    x0 = xfer_cnt;
    for (int n = 0; n < 20 && xfer_cnt == x0; n++) step();
    chk("restart_xfer", 32'(xfer_cnt - x0), 1);
    chk("restart_xfer_pc", 32'(last_xfer_pc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
